// File: rtl/clock_ctrl_if.sv
// rtl/clock_ctrl_if.sv - button, timebase and display bus of the alarm clock controller
interface clock_ctrl_if;
   logic       tick_1hz;
   logic       mode;
   logic       left;
   logic       right;
   logic       up;
   logic       down;
   logic       time_mode;
   logic       active_alarm;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [5:0] al_min;
   logic [4:0] al_hour;
   logic [4:0] disp_hour;
   logic       pm;
   logic [1:0] state;
   logic [1:0] cursor;
   logic       ring;

   modport master (
      output tick_1hz, mode, left, right, up, down, time_mode, active_alarm,
      input  sec, min, hour, al_min, al_hour, disp_hour, pm, state, cursor, ring
   );

   modport slave (
      input  tick_1hz, mode, left, right, up, down, time_mode, active_alarm,
      output sec, min, hour, al_min, al_hour, disp_hour, pm, state, cursor, ring
   );
endinterface

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - 24h timekeeper with set-time/set-alarm adjust FSM and one-minute alarm ring
module clock_ctrl (
   input logic         CP,
   input logic         CR,
   clock_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      RUN       = 2'd0,
      SET_TIME  = 2'd1,
      SET_ALARM = 2'd2,
      ILLEGAL   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] cursor_q, cursor_d;
   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;
   logic [4:0] hour_q, hour_d;
   logic [5:0] al_min_q, al_min_d;
   logic [4:0] al_hour_q, al_hour_d;
   logic       ring_q, ring_d;
   logic [5:0] ring_cnt_q, ring_cnt_d;
   logic       armed_q, armed_d;

   logic       any_pulse;
   logic       lr_press;
   logic       lr_single;
   logic       ud_single;
   logic       tick_adv;
   logic       trigger;

   function automatic logic [5:0] wrap6(input logic [5:0] v, input logic dec);
      if (dec) return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
      return (v >= 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [4:0] wrap5(input logic [4:0] v, input logic dec);
      if (dec) return (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
      return (v >= 5'd23) ? 5'd0 : v + 5'd1;
   endfunction

   always_comb begin
      state_d    = state_q;
      cursor_d   = cursor_q;
      sec_d      = sec_q;
      min_d      = min_q;
      hour_d     = hour_q;
      al_min_d   = al_min_q;
      al_hour_d  = al_hour_q;
      ring_d     = ring_q;
      ring_cnt_d = ring_cnt_q;
      armed_d    = 1'b1;
      trigger    = 1'b0;

      any_pulse = bus.mode | bus.left | bus.right | bus.up | bus.down;
      lr_press  = bus.left | bus.right;
      lr_single = bus.left ^ bus.right;
      ud_single = bus.up ^ bus.down;
      tick_adv  = armed_q && bus.tick_1hz && (state_q == RUN || state_q == SET_ALARM);

      if (tick_adv) begin
         sec_d = wrap6(sec_q, 1'b0);
         if (sec_q >= 6'd59) begin
            min_d = wrap6(min_q, 1'b0);
            if (min_q >= 6'd59) hour_d = wrap5(hour_q, 1'b0);
         end
      end

      // armed_q masks the first edge after reset release so coincident pulses are dropped
      if (armed_q) begin
         if (bus.mode) begin
            case (state_q)
               RUN: begin
                  state_d  = SET_TIME;
                  cursor_d = 2'd0;
               end
               SET_TIME: begin
                  state_d  = SET_ALARM;
                  cursor_d = 2'd1;
               end
               default: state_d = RUN;
            endcase
         end else if (state_q == ILLEGAL) begin
            state_d = RUN;
         end else if (lr_press) begin
            if (lr_single) begin
               if (state_q == SET_TIME) begin
                  if (bus.left) cursor_d = (cursor_q >= 2'd2) ? 2'd0 : cursor_q + 2'd1;
                  else          cursor_d = (cursor_q == 2'd0 || cursor_q > 2'd2) ? 2'd2 : cursor_q - 2'd1;
               end else if (state_q == SET_ALARM) begin
                  cursor_d = (cursor_q == 2'd2) ? 2'd1 : 2'd2;
               end
            end
         end else if (ud_single) begin
            if (state_q == SET_TIME) begin
               case (cursor_q)
                  2'd0:    sec_d  = wrap6(sec_q, bus.down);
                  2'd1:    min_d  = wrap6(min_q, bus.down);
                  2'd2:    hour_d = wrap5(hour_q, bus.down);
                  default: ;
               endcase
            end else if (state_q == SET_ALARM) begin
               if (cursor_q == 2'd2) al_hour_d = wrap5(al_hour_q, bus.down);
               else                  al_min_d  = wrap6(al_min_q, bus.down);
            end
         end

         trigger = (state_q == RUN) && !bus.mode && bus.active_alarm && bus.tick_1hz &&
                   (sec_d == 6'd0) && (min_d == al_min_q) && (hour_d == al_hour_q);

         if (ring_q) begin
            if (any_pulse || !bus.active_alarm || state_q != RUN) begin
               ring_d     = 1'b0;
               ring_cnt_d = 6'd0;
            end else if (bus.tick_1hz) begin
               if (ring_cnt_q >= 6'd59) begin
                  ring_d     = 1'b0;
                  ring_cnt_d = 6'd0;
               end else begin
                  ring_cnt_d = ring_cnt_q + 6'd1;
               end
            end
         end

         if (trigger) begin
            ring_d     = 1'b1;
            ring_cnt_d = 6'd0;
         end
      end
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state_q    <= RUN;
         cursor_q   <= 2'd0;
         sec_q      <= 6'd0;
         min_q      <= 6'd0;
         hour_q     <= 5'd0;
         al_min_q   <= 6'd0;
         al_hour_q  <= 5'd7;
         ring_q     <= 1'b0;
         ring_cnt_q <= 6'd0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cursor_q   <= cursor_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         al_min_q   <= al_min_d;
         al_hour_q  <= al_hour_d;
         ring_q     <= ring_d;
         ring_cnt_q <= ring_cnt_d;
         armed_q    <= armed_d;
      end
   end

   always_comb begin
      bus.disp_hour = hour_q;
      if (bus.time_mode) begin
         if (hour_q == 5'd0)      bus.disp_hour = 5'd12;
         else if (hour_q > 5'd12) bus.disp_hour = hour_q - 5'd12;
      end
   end

   assign bus.pm      = (hour_q >= 5'd12);
   assign bus.sec     = sec_q;
   assign bus.min     = min_q;
   assign bus.hour    = hour_q;
   assign bus.al_min  = al_min_q;
   assign bus.al_hour = al_hour_q;
   assign bus.state   = state_q;
   assign bus.cursor  = cursor_q;
   assign bus.ring    = ring_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - directed bench for clock_ctrl against a seconds-of-day reference model
module tb_clock_ctrl;
   logic CP = 1'b0;
   logic CR = 1'b1;

   clock_ctrl_if bus();
   clock_ctrl dut (.CP(CP), .CR(CR), .bus(bus));

   always #5 CP = ~CP;

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] TK   = 6'b100000;
   localparam logic [5:0] MD   = 6'b010000;
   localparam logic [5:0] LF   = 6'b001000;
   localparam logic [5:0] RT   = 6'b000100;
   localparam logic [5:0] UP   = 6'b000010;
   localparam logic [5:0] DN   = 6'b000001;

   int checks = 0;
   int errors = 0;

   int m_t          = 0;
   int m_al         = 420;
   int m_st         = 0;
   int m_cur        = 0;
   int m_ring_ticks = 0;
   bit m_ring       = 1'b0;
   bit m_skip       = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t = 0; m_al = 420; m_st = 0; m_cur = 0;
      m_ring = 1'b0; m_ring_ticks = 0; m_skip = 1'b1;
   endtask

   task automatic model_step();
      int st0, h, m, s, d, ah, am;
      bit ring0, any, tk;
      if (CR) begin
         model_reset();
         return;
      end
      if (m_skip) begin
         m_skip = 1'b0;
         return;
      end
      st0   = m_st;
      ring0 = m_ring;
      tk    = bus.tick_1hz;
      any   = bus.mode | bus.left | bus.right | bus.up | bus.down;
      if (tk && (st0 == 0 || st0 == 2)) m_t = (m_t + 1) % 86400;
      if (bus.mode) begin
         m_st = (st0 + 1) % 3;
         if (m_st == 1) m_cur = 0;
         else if (m_st == 2) m_cur = 1;
      end else if (bus.left || bus.right) begin
         if (bus.left != bus.right) begin
            if (st0 == 1)      m_cur = bus.left ? (m_cur + 1) % 3 : (m_cur + 2) % 3;
            else if (st0 == 2) m_cur = 3 - m_cur;
         end
      end else if (bus.up != bus.down) begin
         d = bus.up ? 1 : -1;
         h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
         if (st0 == 1) begin
            if (m_cur == 0)      s = (s + d + 60) % 60;
            else if (m_cur == 1) m = (m + d + 60) % 60;
            else                 h = (h + d + 24) % 24;
            m_t = h * 3600 + m * 60 + s;
         end else if (st0 == 2) begin
            ah = m_al / 60; am = m_al % 60;
            if (m_cur == 2) ah = (ah + d + 24) % 24;
            else            am = (am + d + 60) % 60;
            m_al = ah * 60 + am;
         end
      end
      if (ring0) begin
         if (any || !bus.active_alarm || st0 != 0) m_ring = 1'b0;
         else if (tk) begin
            m_ring_ticks++;
            if (m_ring_ticks == 60) m_ring = 1'b0;
         end
      end
      if (st0 == 0 && !bus.mode && bus.active_alarm && tk && (m_t % 60) == 0 && (m_t / 60) == m_al) begin
         m_ring = 1'b1;
         m_ring_ticks = 0;
      end
   endtask

   always @(posedge CR) model_reset();
   always @(posedge CP) model_step();

   always @(posedge CP) begin
      #2;
      chk("sec", 32'(bus.sec), m_t % 60);
      chk("min", 32'(bus.min), (m_t / 60) % 60);
      chk("hour", 32'(bus.hour), m_t / 3600);
      chk("al_min", 32'(bus.al_min), m_al % 60);
      chk("al_hour", 32'(bus.al_hour), m_al / 60);
      chk("state", 32'(bus.state), m_st);
      chk("cursor", 32'(bus.cursor), m_cur);
      chk("ring", 32'(bus.ring), 32'(m_ring));
      chk("pm", 32'(bus.pm), (m_t / 3600) >= 12 ? 1 : 0);
      chk("disp_hour", 32'(bus.disp_hour),
          bus.time_mode ? ((m_t / 3600) + 11) % 12 + 1 : m_t / 3600);
   end

   task automatic p(input logic [5:0] v);
      @(negedge CP);
      {bus.tick_1hz, bus.mode, bus.left, bus.right, bus.up, bus.down} = v;
      @(posedge CP);
      #1;
      {bus.tick_1hz, bus.mode, bus.left, bus.right, bus.up, bus.down} = NONE;
   endtask

   task automatic rep(input logic [5:0] v, input int n);
      for (int i = 0; i < n; i++) p(v);
   endtask

   initial begin
      {bus.tick_1hz, bus.mode, bus.left, bus.right, bus.up, bus.down} = NONE;
      bus.time_mode    = 1'b0;
      bus.active_alarm = 1'b0;

      repeat (2) @(posedge CP);
      #1;
      chk("rst_al_hour", 32'(bus.al_hour), 7);
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_ring", 32'(bus.ring), 0);

      @(negedge CP);
      CR = 1'b0; bus.tick_1hz = 1'b1; bus.mode = 1'b1;
      @(posedge CP);
      #1;
      bus.tick_1hz = 1'b0; bus.mode = 1'b0;
      chk("release_edge_sec", 32'(bus.sec), 0);
      chk("release_edge_state", 32'(bus.state), 0);
      p(TK);
      chk("first_tick_sec", 32'(bus.sec), 1);

      p(MD);
      chk("enter_set_time_cursor", 32'(bus.cursor), 0);
      rep(DN, 3); p(LF); p(DN); p(LF); p(DN);
      chk("down_hour_wrap", 32'(bus.hour), 23);
      chk("set_sec58", 32'(bus.sec), 58);
      p(MD); p(MD);
      chk("back_to_run", 32'(bus.state), 0);
      p(TK);
      chk("t235959_sec", 32'(bus.sec), 59);
      chk("t235959_pm", 32'(bus.pm), 1);
      p(TK);
      chk("midnight_hour", 32'(bus.hour), 0);
      chk("midnight_min", 32'(bus.min), 0);
      chk("midnight_pm", 32'(bus.pm), 0);

      p(MD); p(DN);
      chk("sec_down_wrap", 32'(bus.sec), 59);
      p(UP);
      chk("sec_up_wrap", 32'(bus.sec), 0);
      chk("sec_wrap_no_carry", 32'(bus.min), 0);
      p(RT);
      chk("right_wrap_cursor", 32'(bus.cursor), 2);
      p(LF);
      chk("left_wrap_cursor", 32'(bus.cursor), 0);
      p(LF | RT);
      chk("left_right_noop", 32'(bus.cursor), 0);
      rep(UP, 10);
      p(TK | UP);
      chk("tick_discarded_sec", 32'(bus.sec), 11);
      p(MD | UP);
      chk("mode_beats_up_state", 32'(bus.state), 2);
      chk("alarm_cursor", 32'(bus.cursor), 1);
      chk("mode_beats_up_al_min", 32'(bus.al_min), 0);

      p(TK);
      chk("set_alarm_runs", 32'(bus.sec), 12);
      p(UP);
      chk("al_min_up", 32'(bus.al_min), 1);
      p(DN); p(LF);
      chk("alarm_cursor_toggle", 32'(bus.cursor), 2);
      p(RT);

      p(MD); p(MD); rep(DN, 13); p(LF); p(DN); p(LF); rep(UP, 6); p(MD); p(MD);
      chk("t065959_hour", 32'(bus.hour), 6);
      bus.active_alarm = 1'b1;
      p(TK);
      chk("alarm_ring", 32'(bus.ring), 1);
      chk("alarm_hour", 32'(bus.hour), 7);
      rep(TK, 59);
      chk("ring_59_ticks", 32'(bus.ring), 1);
      p(TK);
      chk("ring_60th_tick", 32'(bus.ring), 0);
      chk("ring_60th_min", 32'(bus.min), 1);

      p(MD); p(DN); p(LF); rep(DN, 2); p(LF); p(DN); p(MD); p(MD);
      p(TK);
      chk("ring_again", 32'(bus.ring), 1);
      p(UP);
      chk("up_cancels_ring", 32'(bus.ring), 0);
      chk("cancel_keeps_min", 32'(bus.min), 0);
      chk("cancel_keeps_sec", 32'(bus.sec), 0);

      p(MD); p(DN); p(LF); p(DN); p(LF); p(DN); p(MD); p(MD);
      bus.active_alarm = 1'b0;
      p(TK);
      chk("disarmed_no_ring", 32'(bus.ring), 0);
      chk("disarmed_hour", 32'(bus.hour), 7);

      p(MD); p(MD); p(UP);
      chk("pre_reset_al_min", 32'(bus.al_min), 1);
      @(negedge CP);
      CR = 1'b1;
      #1;
      chk("async_rst_state", 32'(bus.state), 0);
      chk("async_rst_al_min", 32'(bus.al_min), 0);
      chk("async_rst_al_hour", 32'(bus.al_hour), 7);
      chk("async_rst_hour", 32'(bus.hour), 0);
      @(negedge CP);
      CR = 1'b0;
      @(posedge CP);
      #1;

      bus.time_mode = 1'b1;
      #1;
      chk("h12_midnight_disp", 32'(bus.disp_hour), 12);
      chk("h12_midnight_pm", 32'(bus.pm), 0);
      p(MD); p(LF); p(LF); rep(UP, 12);
      chk("h12_noon_disp", 32'(bus.disp_hour), 12);
      chk("h12_noon_pm", 32'(bus.pm), 1);
      rep(UP, 11);
      chk("h12_23_disp", 32'(bus.disp_hour), 11);
      chk("h12_23_pm", 32'(bus.pm), 1);
      bus.time_mode = 1'b0;
      #1;
      chk("h24_23_disp", 32'(bus.disp_hour), 23);

      rep(NONE, 3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
